// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the TSC memory access stage: word width, timeout
// defaults, controller state encodings and instruction-register field layout.
package mem_access_unit_pkg;

    localparam int unsigned WORD_SIZE        = 16;
    localparam int unsigned MAX_WAIT_DEFAULT = 255;
    localparam int unsigned WAIT_W_DEFAULT   = 8;

    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned REG_W      = 2;
    localparam int unsigned FUNC_W     = 6;
    localparam int unsigned IMM_W      = 8;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RS_LSB     = 10;
    localparam int unsigned RT_LSB     = 8;
    localparam int unsigned RD_LSB     = 6;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned IMM_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_I = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } mau_state_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of an instruction word into its opcode, register,
// function and immediate fields; shared with the datapath.
module instr_field_split
    import mem_access_unit_pkg::*;
(
    input  logic [WORD_SIZE-1:0] ir,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [REG_W-1:0]     rs,
    output logic [REG_W-1:0]     rt,
    output logic [REG_W-1:0]     rd,
    output logic [FUNC_W-1:0]    func,
    output logic [IMM_W-1:0]     imm
);

    assign opcode = ir[OPCODE_LSB +: OPCODE_W];
    assign rs     = ir[RS_LSB +: REG_W];
    assign rt     = ir[RT_LSB +: REG_W];
    assign rd     = ir[RD_LSB +: REG_W];
    assign func   = ir[FUNC_LSB +: FUNC_W];
    assign imm    = ir[IMM_LSB +: IMM_W];

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle TSC CPU: fetch/load/store handshakes with
// external memory, instruction and memory data registers, and a response timeout.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int unsigned WAIT_W   = WAIT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 Reset_N,
    input  logic                 req_fetch,
    input  logic                 req_load,
    input  logic                 req_store,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_err,
    output logic [WORD_SIZE-1:0] ir,
    output logic                 ir_valid,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [REG_W-1:0]     rs,
    output logic [REG_W-1:0]     rt,
    output logic [REG_W-1:0]     rd,
    output logic [FUNC_W-1:0]    func,
    output logic [IMM_W-1:0]     imm,
    output logic [WORD_SIZE-1:0] mdr
);

    mau_state_t           state;
    mau_state_t           state_nxt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [WAIT_W-1:0]    wait_nxt;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] wdata_nxt;
    logic [WORD_SIZE-1:0] address_nxt;
    logic [WORD_SIZE-1:0] ir_nxt;
    logic [WORD_SIZE-1:0] mdr_nxt;
    logic                 readm_nxt;
    logic                 writem_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic                 mem_err_nxt;
    logic                 ir_valid_nxt;
    logic                 timeout_hit;

    // The response edge that would push the counter to MAX_WAIT still wins.
    assign timeout_hit = (MAX_WAIT != 0) && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    assign data = (state == ST_WR) ? wdata_q : {WORD_SIZE{1'bz}};

    always_ff @(posedge clk) begin
        if (!Reset_N) begin
            state    <= ST_IDLE;
            readM    <= 1'b0;
            writeM   <= 1'b0;
            address  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_err  <= 1'b0;
            ir       <= '0;
            ir_valid <= 1'b0;
            mdr      <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            readM    <= readm_nxt;
            writeM   <= writem_nxt;
            address  <= address_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            mem_err  <= mem_err_nxt;
            ir       <= ir_nxt;
            ir_valid <= ir_valid_nxt;
            mdr      <= mdr_nxt;
            wdata_q  <= wdata_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_fetch)      state_nxt = ST_RD_I;
                else if (req_load)  state_nxt = ST_RD_D;
                else if (req_store) state_nxt = ST_WR;
            end
            ST_RD_I, ST_RD_D: begin
                if (inputReady)       state_nxt = ST_DONE;
                else if (timeout_hit) state_nxt = ST_IDLE;
            end
            ST_WR: begin
                if (ackOutput)        state_nxt = ST_DONE;
                else if (timeout_hit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the state being entered.
    always_comb begin
        readm_nxt    = (state_nxt == ST_RD_I) || (state_nxt == ST_RD_D);
        writem_nxt   = (state_nxt == ST_WR);
        busy_nxt     = readm_nxt || writem_nxt;
        done_nxt     = (state_nxt == ST_DONE);
        mem_err_nxt  = mem_err;
        address_nxt  = address;
        wdata_nxt    = wdata_q;
        ir_nxt       = ir;
        ir_valid_nxt = ir_valid;
        mdr_nxt      = mdr;
        wait_nxt     = wait_cnt;
        case (state)
            ST_IDLE: begin
                wait_nxt = '0;
                if (state_nxt == ST_RD_I) begin
                    address_nxt  = pc;
                    ir_valid_nxt = 1'b0;
                end else if (state_nxt != ST_IDLE) begin
                    address_nxt = addr;
                end
                if (state_nxt == ST_WR) wdata_nxt = wdata;
            end
            ST_RD_I: begin
                wait_nxt = wait_cnt + WAIT_W'(1);
                if (state_nxt == ST_DONE) begin
                    ir_nxt       = data;
                    ir_valid_nxt = 1'b1;
                end
                if (state_nxt == ST_IDLE) mem_err_nxt = 1'b1;
            end
            ST_RD_D: begin
                wait_nxt = wait_cnt + WAIT_W'(1);
                if (state_nxt == ST_DONE) mdr_nxt = data;
                if (state_nxt == ST_IDLE) mem_err_nxt = 1'b1;
            end
            ST_WR: begin
                wait_nxt = wait_cnt + WAIT_W'(1);
                if (state_nxt == ST_IDLE) mem_err_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    instr_field_split u_split (
        .ir     (ir),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .func   (func),
        .imm    (imm)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level expectations checked
// every cycle, plus literal checks on key results.
module tb_mem_access_unit;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        Reset_N;
    logic        req_fetch, req_load, req_store;
    logic [15:0] pc, addr, wdata;
    logic        readM, writeM, busy, done, mem_err, ir_valid;
    logic [15:0] address, ir, mdr;
    wire  [15:0] data;
    logic        inputReady, ackOutput;
    logic [3:0]  opcode;
    logic [1:0]  rs, rt, rd;
    logic [5:0]  func;
    logic [7:0]  imm;

    logic        bus_en;
    logic [15:0] bus_val;
    assign data = bus_en ? bus_val : 16'hzzzz;

    always #5 clk = ~clk;

    mem_access_unit #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
        .clk(clk), .Reset_N(Reset_N),
        .req_fetch(req_fetch), .req_load(req_load), .req_store(req_store),
        .pc(pc), .addr(addr), .wdata(wdata),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput),
        .busy(busy), .done(done), .mem_err(mem_err),
        .ir(ir), .ir_valid(ir_valid),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .func(func), .imm(imm),
        .mdr(mdr)
    );

    // Expected DUT outputs for the current cycle
    logic        e_readM, e_writeM, e_busy, e_done, e_mem_err, e_ir_valid;
    logic [15:0] e_address, e_ir, e_mdr, e_wdata;
    bit          chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_readM = 0, obs_writeM = 0, obs_done = 0;
    int cyc = 0, t_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("readM", 32'(readM), 32'(e_readM));
            chk("writeM", 32'(writeM), 32'(e_writeM));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("mem_err", 32'(mem_err), 32'(e_mem_err));
            chk("ir", 32'(ir), 32'(e_ir));
            chk("ir_valid", 32'(ir_valid), 32'(e_ir_valid));
            chk("mdr", 32'(mdr), 32'(e_mdr));
            if (e_busy) chk("address", 32'(address), 32'(e_address));
            if (e_writeM) chk("data_store", 32'(data), 32'(e_wdata));
            else          chk("data_released", 32'(data), 32'(bus_val));
            if (e_ir_valid) begin
                chk("opcode", 32'(opcode), 32'(e_ir[15:12]));
                chk("rs", 32'(rs), 32'(e_ir[11:10]));
                chk("rt", 32'(rt), 32'(e_ir[9:8]));
                chk("rd", 32'(rd), 32'(e_ir[7:6]));
                chk("func", 32'(func), 32'(e_ir[5:0]));
                chk("imm", 32'(imm), 32'(e_ir[7:0]));
            end
            if (readM === 1'b1)  obs_readM++;
            if (writeM === 1'b1) obs_writeM++;
            if (done === 1'b1) begin
                obs_done++;
                t_done = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_reset();
        e_readM = 0; e_writeM = 0; e_busy = 0; e_done = 0; e_mem_err = 0;
        e_ir = '0; e_ir_valid = 0; e_mdr = '0; e_address = '0; e_wdata = '0;
        bus_en = 1'b1; bus_val = '0;
    endtask

    // One transaction. lat = strobe cycle in which memory responds (0 = never);
    // rst_at = strobe cycle in which a one-cycle reset is applied (0 = none).
    task automatic txn(input logic f, input logic l, input logic s,
                       input logic [15:0] a_pc, input logic [15:0] a_addr,
                       input logic [15:0] a_wd, input int lat, input logic [15:0] rdata,
                       input bit hold_load, input int rst_at);
        int kind;
        kind = f ? 0 : (l ? 1 : 2);
        req_fetch = f; req_load = l; req_store = s;
        pc = a_pc; addr = a_addr; wdata = a_wd;
        tick();
        req_fetch = 0; req_store = 0; req_load = hold_load;
        e_busy = 1; e_readM = (kind != 2); e_writeM = (kind == 2);
        e_address = (kind == 0) ? a_pc : a_addr;
        if (kind == 0) e_ir_valid = 0;
        if (kind == 2) begin
            e_wdata = a_wd;
            bus_en  = 1'b0;
        end
        for (int k = 1; k <= int'(MW); k++) begin
            if (k == rst_at) begin
                Reset_N = 0;
                tick();
                Reset_N = 1;
                exp_reset();
                inputReady = 1; ackOutput = 1; bus_val = rdata;
                tick();
                inputReady = 0; ackOutput = 0; bus_val = '0;
                return;
            end
            if (k == lat) begin
                if (kind == 2) ackOutput = 1;
                else begin
                    inputReady = 1;
                    bus_val = rdata;
                end
            end else begin
                if (kind == 2) inputReady = 1;
                else ackOutput = 1;
            end
            tick();
            inputReady = 0; ackOutput = 0;
            if (k == lat) begin
                bus_en = 1'b1; bus_val = '0;
                e_readM = 0; e_writeM = 0; e_busy = 0; e_done = 1;
                if (kind == 0) begin
                    e_ir = rdata;
                    e_ir_valid = 1;
                end else if (kind == 1) begin
                    e_mdr = rdata;
                end
                // Stray responses and a store request during DONE must be ignored
                inputReady = 1; ackOutput = 1;
                if (!hold_load) req_store = 1;
                tick();
                inputReady = 0; ackOutput = 0; req_store = 0;
                e_done = 0;
                return;
            end
            if (k == int'(MW)) begin
                bus_en = 1'b1; bus_val = '0;
                e_readM = 0; e_writeM = 0; e_busy = 0; e_mem_err = 1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int br, bw, bd, t_req;
        Reset_N = 0; req_fetch = 0; req_load = 0; req_store = 0;
        pc = '0; addr = '0; wdata = '0; inputReady = 0; ackOutput = 0;
        exp_reset();
        tick();
        chk_en = 1'b1;
        tick();
        Reset_N = 1;
        chk("reset_address", 32'(address), 32'h0);
        tick();

        // Fetch with a two-cycle memory response
        br = obs_readM; bd = obs_done;
        txn(1, 0, 0, 16'h0004, 16'h0000, 16'h0000, 2, 16'hF1C0, 0, 0);
        chk("fetch_readM_cycles", 32'(obs_readM - br), 32'd2);
        chk("fetch_done_pulses", 32'(obs_done - bd), 32'd1);
        chk("fetch_ir", 32'(ir), 32'hF1C0);
        chk("fetch_opcode", 32'(opcode), 32'hF);
        chk("fetch_rs", 32'(rs), 32'h0);
        chk("fetch_rt", 32'(rt), 32'h1);
        chk("fetch_rd", 32'(rd), 32'h3);
        chk("fetch_func", 32'(func), 32'h0);

        // Load then store
        bd = obs_done;
        txn(0, 1, 0, 16'h0000, 16'h0030, 16'h0000, 2, 16'hBEEF, 0, 0);
        chk("load_mdr", 32'(mdr), 32'hBEEF);
        chk("load_done_pulses", 32'(obs_done - bd), 32'd1);
        bw = obs_writeM; bd = obs_done;
        txn(0, 0, 1, 16'h0000, 16'h0031, 16'h1234, 2, 16'h0000, 0, 0);
        chk("store_writeM_cycles", 32'(obs_writeM - bw), 32'd2);
        chk("store_done_pulses", 32'(obs_done - bd), 32'd1);

        // All three requests together: fetch wins, a held load waits for IDLE
        bw = obs_writeM; bd = obs_done;
        txn(1, 1, 1, 16'h0008, 16'h0040, 16'h5555, 3, 16'h9ABC, 1, 0);
        chk("prio_no_store", 32'(obs_writeM - bw), 32'd0);
        chk("prio_done_pulses", 32'(obs_done - bd), 32'd1);
        txn(0, 1, 0, 16'h0008, 16'h0040, 16'h0000, 1, 16'hCAFE, 0, 0);
        chk("held_load_mdr", 32'(mdr), 32'hCAFE);

        // Best case: response in the first strobe cycle
        t_req = cyc;
        txn(1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h4A85, 0, 0);
        chk("best_case_latency", 32'(t_done - t_req), 32'd2);
        chk("best_case_ir", 32'(ir), 32'h4A85);

        // Response exactly in the last permitted cycle still succeeds
        txn(0, 1, 0, 16'h0000, 16'h0050, 16'h0000, int'(MW), 16'h0F0F, 0, 0);
        chk("boundary_mem_err", 32'(mem_err), 32'h0);
        chk("boundary_mdr", 32'(mdr), 32'h0F0F);

        // Timeout on a fetch, then a normal fetch with the sticky error
        br = obs_readM; bd = obs_done;
        txn(1, 0, 0, 16'h0020, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
        chk("timeout_readM_cycles", 32'(obs_readM - br), 32'd4);
        chk("timeout_no_done", 32'(obs_done - bd), 32'd0);
        chk("timeout_mem_err", 32'(mem_err), 32'h1);
        tick();
        bd = obs_done;
        txn(1, 0, 0, 16'h0024, 16'h0000, 16'h0000, 2, 16'h2345, 0, 0);
        chk("after_timeout_ir", 32'(ir), 32'h2345);
        chk("after_timeout_mem_err", 32'(mem_err), 32'h1);
        chk("after_timeout_done", 32'(obs_done - bd), 32'd1);

        // Reset in the middle of a load
        bd = obs_done;
        txn(0, 1, 0, 16'h0000, 16'h0060, 16'h0000, 0, 16'h7777, 0, 2);
        chk("rst_mdr", 32'(mdr), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_mem_err", 32'(mem_err), 32'h0);
        chk("rst_address", 32'(address), 32'h0);
        chk("rst_no_done", 32'(obs_done - bd), 32'd0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-side stage of the multicycle TSC CPU. It sits directly upstream of the controller FSM and performs instruction fetch and data load/store handshakes with external memory. It latches the fetched word into the instruction register (IR) and supplies the 4-bit opcode and decoded fields to the controller and datapath. Load data is latched into the memory data register (MDR). Each transaction completes with a one-cycle done pulse, which is the controller's cue to advance out of IF or its MEM states.

Parameters:
WORD_SIZE, 16, data/address width
MAX_WAIT, 255, cycles to wait for a memory response before aborting; 0 disables the timeout
WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  in  1  clock
Reset_N  in  1  synchronous, active-low reset
req_fetch  in  1  controller request: read instruction at pc
req_load  in  1  controller request: read data at addr
req_store  in  1  controller request: write wdata to addr
pc  in  16  fetch address
addr  in  16  load/store address
wdata  in  16  store data
readM  out  1  memory read strobe
writeM  out  1  memory write strobe
address  out  16  memory address
data  inout  16  memory data bus; driven only during a store, Z otherwise
inputReady  in  1  memory read-data-valid pulse
ackOutput  in  1  memory write-accepted pulse
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
mem_err  out  1  sticky timeout flag
ir  out  16  instruction register
ir_valid  out  1  ir holds a fetched word
opcode  out  4  ir[15:12]
rs, rt, rd  out  2 each  ir[11:10], ir[9:8], ir[7:6]
func  out  6  ir[5:0]
imm  out  8  ir[7:0]
mdr  out  16  load data register

Behaviour:
- Reset (Reset_N low at a posedge): state IDLE; readM=0, writeM=0, address=0, data=Z, busy=0, done=0, mem_err=0, ir=0, ir_valid=0, mdr=0, wait counter=0. A reset mid-transaction abandons it at that edge; no done pulse is produced.
- States: IDLE, RD_I, RD_D, WR, DONE.
- IDLE: samples requests only here. If several requests are high together, priority is fetch > load > store. The request is captured at the edge and the unit moves to RD_I, RD_D or WR with busy=1. Address is registered: pc for a fetch, addr otherwise; store data is registered from wdata. Requests raised while busy are ignored and are not queued.
- RD_I/RD_D: readM=1, with address held stable.
  - On the first edge where inputReady=1, data is latched into ir (ir_valid←1) or into mdr, and the state moves to DONE.
  - ir_valid drops to 0 when a new fetch starts.
- WR: writeM=1, and data is driven with the registered store data. On the edge where ackOutput=1, the state moves to DONE.
- Minimum latency: request edge → strobe asserted the next cycle. If the memory responds in that same cycle, done is high in the cycle after the response edge. Best case is request → done in 2 cycles.
- DONE: done=1 for exactly one cycle, with strobes already deasserted and busy=0. Then IDLE. A request present during DONE is not accepted until IDLE.
- Timeout: the wait counter clears on entry to RD_I/RD_D/WR and increments each cycle there without a response.
  - When the counter reaches MAX_WAIT (and MAX_WAIT≠0), mem_err is set, strobes drop, and the state returns to IDLE with no done pulse.
  - mem_err clears only on reset.
  - A response arriving in the same cycle the counter hits MAX_WAIT counts as success.
- inputReady/ackOutput seen in IDLE or DONE are ignored. The wrong-type response (ackOutput during a read, inputReady during a write) is ignored.
- Decoded fields are combinational from ir and valid only while ir_valid=1.
- Data bus: data is driven only while state==WR. No bus contention in any other state, including reset.

Decomposition:
- Shared package/include: WORD_SIZE; IR field bit positions; state encodings; MAX_WAIT default. Opcodes stay in the existing opcodes include.
- One sub-module: instr_field_split. It is purely combinational, splitting ir into opcode, rs, rt, rd, func and imm, and is reused by the datapath.

Test Plan:
- Fetch: pc=16'h0004, req_fetch pulse; memory returns 16'hF1C0 with inputReady 2 cycles after readM. Required: readM held 2 cycles, address=0004; ir=F1C0, ir_valid=1, opcode=F, rs=0, rt=1, rd=3, func=0; done for 1 cycle; readM low in the done cycle.
- Load then store: req_load with addr=0x0030, memory returns 0xBEEF → mdr=BEEF. Then req_store with addr=0x0031, wdata=0x1234, ackOutput after 1 cycle → writeM high, data=1234 during WR, Z afterwards; done pulses once per transaction.
- Simultaneous req_fetch, req_load and req_store → a fetch only (readM, address=pc); a req_load held during busy produces no second transaction until it is re-sampled in IDLE.
- Timeout with MAX_WAIT=4 and no inputReady → readM high for 4 cycles; mem_err=1; no done; next req_fetch proceeds normally with mem_err still 1.
- Reset_N low for 1 cycle during RD_D → readM=0, busy=0, done=0, ir_valid=0, mdr=0, data=Z after that edge; a late inputReady is ignored.
- Best case: memory responds in the first strobe cycle → done asserted 2 cycles after the request edge; ir updated at the response edge.
